traffic_phase_ctrl: RTL and testbench

Six-phase, two-direction traffic-light sequencer with a per-second countdown. It drives the north-south (NS) and east-west (EW) lamp outputs and produces 7-bit binary "seconds remaining" values for each direction. The display path feeds these values to the existing binary-to-BCD converter, changetoBCD, which is instantiated outside this block. The block owns all timing: prescaler, phase FSM and countdown.

---
 rtl/tlc_pkg.sv | 24 ++
 rtl/tlc_sec_prescaler.sv | 29 ++
 rtl/traffic_phase_ctrl.sv | 142 ++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic phase controller.
package tlc_pkg;

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR_A = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR_B = 3'd5
  } phase_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam int BCD_MAX = 99;

  // Clamp a 9-bit seconds sum so the BCD display never sees more than 99.
  function automatic logic [6:0] sat_bcd(input logic [8:0] val);
    return (val > 9'(BCD_MAX)) ? 7'(BCD_MAX) : val[6:0];
  endfunction

endpackage

// File: rtl/tlc_sec_prescaler.sv
// Divides the system clock down to a one-cycle pulse per second.
// The count holds while en is low so a paused second resumes where it stopped.
module tlc_sec_prescaler #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sec_tick
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] pcnt;

  assign sec_tick = en && (pcnt == LAST);

  // Cycle counter within the current second, wrapping on the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (en) begin
      if (pcnt == LAST) pcnt <= '0;
      else              pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Six-phase NS/EW traffic sequencer with per-second countdown and
// seconds-remaining outputs for the external BCD display.
// Optional pedestrian green cut: define TLC_PED_REQ_EN.
module traffic_phase_ctrl
  import tlc_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int GREEN_S       = 30,
  parameter int YELLOW_S      = 3,
  parameter int ALLRED_S      = 2,
  parameter int PED_CUT_S     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
`ifdef TLC_PED_REQ_EN
  input  logic       ped_req,
`endif
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [6:0] ns_remain,
  output logic [6:0] ew_remain,
  output logic [2:0] phase,
  output logic       sec_tick
);

  localparam logic [6:0] G7   = 7'(GREEN_S);
  localparam logic [6:0] Y7   = 7'(YELLOW_S);
  localparam logic [6:0] A7   = 7'(ALLRED_S);
  localparam logic [6:0] CUT7 = 7'(PED_CUT_S);
  localparam logic [8:0] G9   = 9'(GREEN_S);
  localparam logic [8:0] Y9   = 9'(YELLOW_S);
  localparam logic [8:0] A9   = 9'(ALLRED_S);

  phase_e     state, next_state;
  logic [6:0] cnt, next_cnt;
  logic       ped_cut;
  logic [8:0] cnt9, ns_sum, ew_sum;

  function automatic phase_e succ(input phase_e p);
    case (p)
      NS_G:    return NS_Y;
      NS_Y:    return AR_A;
      AR_A:    return EW_G;
      EW_G:    return EW_Y;
      EW_Y:    return AR_B;
      default: return NS_G;
    endcase
  endfunction

  function automatic logic [6:0] dur_of(input phase_e p);
    case (p)
      NS_G, EW_G: return G7;
      NS_Y, EW_Y: return Y7;
      default:    return A7;
    endcase
  endfunction

  tlc_sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sec_tick(sec_tick)
  );

`ifdef TLC_PED_REQ_EN
  logic ped_pend;
  logic enter_y;

  assign enter_y = (state != next_state) && (next_state == NS_Y || next_state == EW_Y);
  assign ped_cut = ped_pend && (state == NS_G || state == EW_G);

  // Pending pedestrian request; a new request wins over the clear on yellow entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ped_pend <= 1'b0;
    else if (ped_req) ped_pend <= 1'b1;
    else if (enter_y) ped_pend <= 1'b0;
  end
`else
  assign ped_cut = 1'b0;
`endif

  // Phase and countdown registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= AR_B;
      cnt   <= A7;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Countdown per second; advance the phase when the last second expires.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      NS_G, NS_Y, AR_A, EW_G, EW_Y, AR_B: begin
        if (sec_tick) begin
          if (cnt > 7'd1) begin
            if (ped_cut && cnt > CUT7) next_cnt = CUT7;
            else                       next_cnt = cnt - 7'd1;
          end else begin
            next_state = succ(state);
            next_cnt   = dur_of(succ(state));
          end
        end
      end
      default: begin
        next_state = AR_B;
        next_cnt   = A7;
      end
    endcase
  end

  assign cnt9 = {2'b00, cnt};

  // Lamp decode and seconds until each direction's lamp next changes.
  always_comb begin
    ns_light = LAMP_R;
    ew_light = LAMP_R;
    ns_sum   = cnt9;
    ew_sum   = cnt9;
    case (state)
      NS_G: begin ns_light = LAMP_G; ew_sum = cnt9 + Y9 + A9; end
      NS_Y: begin ns_light = LAMP_Y; ew_sum = cnt9 + A9; end
      AR_A: begin ns_sum = cnt9 + G9 + Y9 + A9; end
      EW_G: begin ew_light = LAMP_G; ns_sum = cnt9 + Y9 + A9; end
      EW_Y: begin ew_light = LAMP_Y; ns_sum = cnt9 + A9; end
      AR_B: begin ew_sum = cnt9 + G9 + Y9 + A9; end
      default: begin end
    endcase
  end

  assign ns_remain = sat_bcd(ns_sum);
  assign ew_remain = sat_bcd(ew_sum);
  assign phase     = state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized bench for traffic_phase_ctrl against a seconds-level reference model.
// Two instances: the small test configuration and a large one exercising saturation.
module tb_traffic_phase_ctrl;

  localparam int TPS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
`ifdef TLC_PED_REQ_EN
  logic ped_req = 1'b0;
  bit   ped_on = 1'b1;
  int   m_pend[2];
`endif

  logic [2:0] ns_light0, ew_light0, phase0, ns_light1, ew_light1, phase1;
  logic [6:0] ns_rem0, ew_rem0, ns_rem1, ew_rem1;
  logic       tick0, tick1;

  int checks = 0;
  int failures = 0;
  int m_phase[2];
  int m_left[2];
  int m_pcnt;
  int durs[2][6];
  bit reached;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .TICKS_PER_SEC(TPS), .GREEN_S(5), .YELLOW_S(2), .ALLRED_S(1), .PED_CUT_S(2)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en),
`ifdef TLC_PED_REQ_EN
    .ped_req(ped_req),
`endif
    .ns_light(ns_light0), .ew_light(ew_light0), .ns_remain(ns_rem0),
    .ew_remain(ew_rem0), .phase(phase0), .sec_tick(tick0)
  );

  traffic_phase_ctrl #(
    .TICKS_PER_SEC(TPS), .GREEN_S(90), .YELLOW_S(9), .ALLRED_S(5), .PED_CUT_S(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
`ifdef TLC_PED_REQ_EN
    .ped_req(ped_req),
`endif
    .ns_light(ns_light1), .ew_light(ew_light1), .ns_remain(ns_rem1),
    .ew_remain(ew_rem1), .phase(phase1), .sec_tick(tick1)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Lamp code (4=red,2=yellow,1=green) shown by a direction (0=NS,1=EW) in phase p.
  function automatic int lampOf(input int dir, input int p);
    if (dir == 0) return (p == 0) ? 1 : (p == 1) ? 2 : 4;
    return (p == 3) ? 1 : (p == 4) ? 2 : 4;
  endfunction

  // Seconds until the direction's lamp changes: walk forward through the phase ring.
  function automatic int expRemain(input int k, input int dir);
    int p;
    int total;
    p = m_phase[k];
    total = m_left[k];
    for (int i = 1; i < 6; i++) begin
      if (lampOf(dir, (p + i) % 6) != lampOf(dir, p)) break;
      total += durs[k][(p + i) % 6];
    end
    return (total > 99) ? 99 : total;
  endfunction

  task automatic resetModel();
    m_pcnt = 0;
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 5;
      m_left[k]  = durs[k][5];
`ifdef TLC_PED_REQ_EN
      m_pend[k]  = 0;
`endif
    end
  endtask

  task automatic updateModel(input logic en_v);
    for (int k = 0; k < 2; k++) begin
`ifdef TLC_PED_REQ_EN
      bit entered_y;
      entered_y = 1'b0;
`endif
      if (en_v && m_pcnt == TPS - 1) begin
        if (m_left[k] > 1) begin
`ifdef TLC_PED_REQ_EN
          if (m_pend[k] != 0 && (m_phase[k] == 0 || m_phase[k] == 3) && m_left[k] > 2)
            m_left[k] = 2;
          else
`endif
            m_left[k]--;
        end else begin
          m_phase[k] = (m_phase[k] + 1) % 6;
          m_left[k]  = durs[k][m_phase[k]];
`ifdef TLC_PED_REQ_EN
          entered_y  = (m_phase[k] == 1 || m_phase[k] == 4);
`endif
        end
      end
`ifdef TLC_PED_REQ_EN
      if (ped_req) m_pend[k] = 1;
      else if (entered_y) m_pend[k] = 0;
`endif
    end
    if (en_v) m_pcnt = (m_pcnt == TPS - 1) ? 0 : m_pcnt + 1;
  endtask

  task automatic compareAll();
    int exp_tick;
    exp_tick = (en && m_pcnt == TPS - 1) ? 1 : 0;
    checkOutput("tick0", tick0, exp_tick);
    checkOutput("phase0", phase0, m_phase[0]);
    checkOutput("ns_light0", ns_light0, lampOf(0, m_phase[0]));
    checkOutput("ew_light0", ew_light0, lampOf(1, m_phase[0]));
    checkOutput("ns_remain0", ns_rem0, expRemain(0, 0));
    checkOutput("ew_remain0", ew_rem0, expRemain(0, 1));
    checkOutput("tick1", tick1, exp_tick);
    checkOutput("phase1", phase1, m_phase[1]);
    checkOutput("ns_light1", ns_light1, lampOf(0, m_phase[1]));
    checkOutput("ns_remain1", ns_rem1, expRemain(1, 0));
    checkOutput("ew_remain1", ew_rem1, expRemain(1, 1));
  endtask

  // One clock: drive at negedge, check just after, advance model at posedge.
  task automatic applyStimulus(input logic en_v);
    @(negedge clk);
    en = en_v;
`ifdef TLC_PED_REQ_EN
    ped_req = ped_on && ($urandom_range(0, 15) == 0);
`endif
    #1;
    compareAll();
    @(posedge clk);
    updateModel(en_v);
  endtask

  // Asynchronous reset mid-cycle, checked immediately and one cycle later.
  task automatic doReset();
    @(negedge clk);
    en = 1'b0;
`ifdef TLC_PED_REQ_EN
    ped_req = 1'b0;
`endif
    rst_n = 1'b0;
    #1;
    resetModel();
    compareAll();
    checkOutput("rst_ns_remain0", ns_rem0, 1);
    checkOutput("rst_ew_remain0", ew_rem0, 9);
    checkOutput("rst_ew_remain1_sat", ew_rem1, 99);
    @(negedge clk);
    #1;
    compareAll();
    rst_n = 1'b1;
  endtask

  initial begin
    durs[0] = '{5, 2, 1, 5, 2, 1};
    durs[1] = '{90, 9, 5, 90, 9, 5};
    resetModel();

    doReset();
    repeat (8) applyStimulus(1'b1);
    checkOutput("s1_phase_ns_g", phase0, 0);

    repeat (300) applyStimulus($urandom_range(0, 7) != 0);

`ifdef TLC_PED_REQ_EN
    ped_on = 1'b0;
`endif
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      applyStimulus(1'b1);
      reached = (m_phase[0] == 0 && m_left[0] == 3 && m_pcnt == 2);
    end
    checkOutput("reach_freeze_point", int'(reached), 1);
    repeat (10) applyStimulus(1'b0);
    repeat (4) applyStimulus(1'b1);

    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      applyStimulus($urandom_range(0, 7) != 0);
      reached = (m_phase[0] == 4);
    end
    checkOutput("reach_ew_y", int'(reached), 1);
    doReset();
    repeat (8) applyStimulus(1'b1);
    checkOutput("s5_phase_ns_g", phase0, 0);
`ifdef TLC_PED_REQ_EN
    ped_on = 1'b1;
`endif

    repeat (200) applyStimulus($urandom_range(0, 7) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
